// File: rtl/uart_loader.sv
// UART boot loader: receives a length-prefixed word stream and writes it into instruction memory.
// Define UART_LOADER_CHECKSUM_EN to require a trailing byte that makes the 8-bit data sum zero.
module uart_loader #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned TIMEOUT_CYC = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              start,
    output logic              cpu_hold,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);
    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CKSUM, DONE, ERR} state_t;
    logic [7:0] sum;
`else
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} state_t;
`endif

    rx_state_t     rx_state;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift, rx_byte;
    logic          byte_valid, frame_err;

    state_t        state;
    logic          start_q;
    logic [15:0]   len;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_cnt     <= rx_cnt + CW'(1);
            case (rx_state)
                RX_IDLE:
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                RX_START:
                    if (rx_cnt == CW'(HALF - 1)) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end
                RX_DATA:
                    if (rx_cnt == CW'(DIV - 1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                RX_STOP:
                    if (rx_cnt == CW'(DIV - 1)) begin
                        rx_state   <= RX_IDLE;
                        rx_byte    <= rx_shift;
                        byte_valid <= rx_s2;
                        frame_err  <= !rx_s2;
                    end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Edge detector loads the live switch level on reset so a switch already high is not a trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q    <= start;
            state      <= IDLE;
            cpu_hold   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            len        <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            tcnt       <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            start_q <= start;
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start && !start_q) begin
                        state      <= LEN0;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        byte_idx   <= '0;
                        tcnt       <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                default: begin
                    if (frame_err) begin
                        state <= ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        tcnt <= '0;
                        case (state)
                            LEN0: begin
                                len[7:0] <= rx_byte;
                                state    <= LEN1;
                            end
                            LEN1: begin
                                len[15:8] <= rx_byte;
                                if ({rx_byte, len[7:0]} == 16'd0) begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    cpu_hold <= 1'b0;
                                    busy     <= 1'b0;
                                end else if (32'({rx_byte, len[7:0]}) > (32'd1 << ADDR_W)) begin
                                    state <= ERR;
                                    err   <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    state <= DATA;
                                end
                            end
                            DATA: begin
                                byte_idx <= byte_idx + 2'd1;
                                word_buf <= {rx_byte, word_buf[23:8]};
`ifdef UART_LOADER_CHECKSUM_EN
                                sum      <= sum + rx_byte;
`endif
                                if (byte_idx == 2'd3) begin
                                    imem_we    <= 1'b1;
                                    imem_addr  <= word_count[ADDR_W-1:0];
                                    imem_wdata <= {rx_byte, word_buf};
                                    word_count <= word_count + (ADDR_W + 1)'(1);
                                    if (32'(word_count) + 32'd1 == 32'(len)) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                        state    <= CKSUM;
`else
                                        state    <= DONE;
                                        done     <= 1'b1;
                                        cpu_hold <= 1'b0;
                                        busy     <= 1'b0;
`endif
                                    end
                                end
                            end
`ifdef UART_LOADER_CHECKSUM_EN
                            CKSUM: begin
                                busy <= 1'b0;
                                if (8'(sum + rx_byte) == 8'd0) begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    cpu_hold <= 1'b0;
                                end else begin
                                    state <= ERR;
                                    err   <= 1'b1;
                                end
                            end
`endif
                            default: state <= ERR;
                        endcase
                    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        state <= ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_HZ/BAUD cycles, integer-truncated.
REQ-003 SHALL have parameter ADDR_W, default 14, instruction-memory word-address width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 100000000, maximum idle cycles between received bytes while loading.
REQ-005 clk  input  1  system clock; all state updates on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rx  input  1  UART receive line, asynchronous to clk, idle high.
REQ-008 start  input  1  load request, level from a switch; a rising edge is the trigger.
REQ-009 cpu_hold  output  1  holds the CPU in reset while high.
REQ-010 imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-011 imem_addr  output  ADDR_W  word address of the current write.
REQ-012 imem_wdata  output  32  word being written.
REQ-013 busy  output  1  high in any state other than IDLE, DONE or ERR.
REQ-014 done  output  1  load completed successfully.
REQ-015 err  output  1  load aborted.
REQ-016 word_count  output  ADDR_W+1  number of words written in the current or last load.

Function
REQ-017 SHALL pass rx through a 2-FF synchronizer with both stages reset to 1.
REQ-018 Byte receiver SHALL:
- detect start as a synchronized high-to-low transition;
- re-check low at DIV/2;
- sample 8 data bits LSB-first at DIV intervals from that point;
- sample the stop bit one DIV later.
REQ-019 A stop bit sampled low SHALL be a framing error; a start bit that is not low at DIV/2 SHALL be discarded silently.
REQ-020 FSM states SHALL be IDLE, LEN0, LEN1, DATA, CKSUM, DONE and ERR.
REQ-021 A start rising edge in IDLE, DONE or ERR SHALL:
- enter LEN0;
- set cpu_hold=1;
- clear done, err and word_count.
REQ-022 A start edge while busy SHALL be ignored.
REQ-023 LEN0/LEN1 SHALL receive N, a 16-bit little-endian word count.
REQ-024 N=0 SHALL go straight to DONE; N>2^ADDR_W SHALL go to ERR.
REQ-025 DATA SHALL assemble 4 bytes little-endian per word.
REQ-026 On the 4th byte, the FSM SHALL pulse imem_we for exactly one cycle on the next clk, with imem_addr=word_count[ADDR_W-1:0] and imem_wdata=the assembled word.
REQ-027 word_count SHALL increment in the same cycle as the write pulse.
REQ-028 After the write that makes word_count==N, the FSM SHALL go to DONE, or to CKSUM when REQ-039 applies.
REQ-029 A framing error, or TIMEOUT_CYC cycles without a completed byte in LEN0/LEN1/DATA/CKSUM, SHALL go to ERR.
REQ-030 DONE SHALL:
- set done=1 and cpu_hold=0;
- hold that state until the next start edge.
REQ-031 ERR SHALL:
- set err=1 and keep cpu_hold=1;
- hold that state until the next start edge.
- Words already written SHALL NOT be rolled back.
REQ-032 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.
REQ-033 The full-range boundary N=2^ADDR_W SHALL be accepted; the final address SHALL be 2^ADDR_W-1, with no wrap-around.

Reset
REQ-034 rst SHALL immediately clear every state bit regardless of the current state, including mid-byte or mid-word.
REQ-035 State SHALL return to IDLE.
REQ-036 On reset, these outputs SHALL be 0: cpu_hold, imem_we, imem_addr, imem_wdata, busy, done, err, word_count.
REQ-037 The rx synchronizer SHALL reset to 1.
REQ-038 The start-edge detector SHALL reset to the sampled start level, so a switch already high at reset does not trigger a load.

Configuration
REQ-039 With UART_LOADER_CHECKSUM_EN defined:
- the module SHALL keep an 8-bit running sum of the data bytes only;
- after the last word it SHALL enter CKSUM and receive one byte C;
- it SHALL go to DONE if (sum+C) mod 256 == 0, else ERR.
REQ-040 Without UART_LOADER_CHECKSUM_EN:
- the CKSUM state and the sum logic SHALL be absent;
- the last word SHALL lead directly to DONE.

Verification
REQ-041 Bench SHALL use CLK_HZ=1000000 and BAUD=100000, giving DIV=10.
REQ-042 Basic load: start edge, bytes 02 00 78 56 34 12 EF BE AD DE -> writes 0x12345678@0 then 0xDEADBEEF@1; done=1, cpu_hold=0, word_count=2.
REQ-043 Empty load: start edge, bytes 00 00 -> DONE with no imem_we pulse and word_count=0.
REQ-044 Framing error: a third byte sent with stop bit 0 -> err=1, cpu_hold=1, done=0.
REQ-045 Timeout: start edge then 1 byte, then silence, with TIMEOUT_CYC=500 -> err=1 at most 500 cycles after that byte; a new start edge clears it.
REQ-046 Checksum (macro defined): load 01 00 01 02 03 04 followed by F6 -> done=1; repeat with F5 -> err=1, and word 0x04030201 still written@0.
REQ-047 Reset mid-operation: assert rst after the second DATA byte -> all outputs 0 next cycle; the following full load works.
